data_mem_responder: RTL and testbench
=====================================

DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 Parameter DEPTH_WORDS, default 256: number of 32-bit words; power of two, >= 4.
REQ-002 Parameter LATENCY, default 2: cycles from request acceptance to response; >= 1.
REQ-003 Port clk  input  1: single clock; all state updates on rising edge.
REQ-004 Port reset  input  1: synchronous, active-high reset.
REQ-005 Port req_valid  input  1: initiator presents a request.
REQ-006 Port req_ready  output  1: responder can accept a request.
REQ-007 Port req_write  input  1: 1 = store, 0 = load.
REQ-008 Port req_funct3  input  3: RV32I load/store width code.
REQ-009 Port req_addr  input  32: byte address.
REQ-010 Port req_wdata  input  32: store data, right-aligned.
REQ-011 Port resp_valid  output  1: response available.
REQ-012 Port resp_ready  input  1: initiator consumes the response.
REQ-013 Port resp_rdata  output  32: load result, extended; 0 for stores and errors.
REQ-014 Port resp_error  output  1: request was misaligned, illegal or out of range.

Function
REQ-015 The FSM SHALL have states IDLE, WAIT and RESP; req_ready = 1 only in IDLE; resp_valid = 1 only in RESP.
REQ-016 In IDLE, req_valid && req_ready SHALL latch write, funct3, addr and wdata, load the counter with LATENCY-1, and enter WAIT.
REQ-017 In WAIT, the counter SHALL decrement each cycle; at counter == 0 the access is performed and the FSM enters RESP, so resp_valid rises exactly LATENCY cycles after the accepting edge.
REQ-018 In RESP, resp_valid, resp_rdata and resp_error SHALL hold stable until resp_ready = 1; that edge returns the FSM to IDLE, with no back-to-back acceptance on the same edge.
REQ-019 req_valid and all request fields SHALL be ignored outside IDLE.
REQ-020 The word index SHALL be addr[log2(DEPTH_WORDS)+1:2]; addr >= 4*DEPTH_WORDS is out of range.
REQ-021 The width codes SHALL be: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU for loads; 000 SB, 001 SH, 010 SW for stores; any other code is illegal.
REQ-022 Alignment SHALL be: halfword requires addr[0] = 0; word requires addr[1:0] = 0.
REQ-023 An error request SHALL leave memory unmodified and return resp_error = 1, resp_rdata = 0.
REQ-024 SB SHALL write byte lane addr[1:0] from wdata[7:0]; SH SHALL write halfword lane addr[1] from wdata[15:0]; SW SHALL write the full word; other lanes stay unchanged.
REQ-025 LB and LH SHALL sign-extend the selected lane, LBU and LHU SHALL zero-extend it, and LW SHALL return the word.
REQ-026 A store SHALL commit exactly once, at the WAIT-to-RESP edge.
REQ-027 A load SHALL sample memory at that same edge, so it sees all earlier committed stores.

Reset
REQ-028 When reset = 1 at a rising edge, the FSM SHALL go to IDLE, the counter to 0, resp_valid to 0, resp_rdata to 0 and resp_error to 0.
REQ-029 req_ready SHALL be 0 in any cycle where reset = 1, and 1 in the first cycle after reset deasserts.
REQ-030 Reset in WAIT SHALL discard the pending request: no memory write and no response.
REQ-031 Reset in RESP SHALL drop the pending response.
REQ-032 Memory contents SHALL NOT be altered by reset.

Verification
REQ-033 The bench SHALL cover: SW addr 0x10, data 0xDEADBEEF; then LW 0x10 -> rdata 0xDEADBEEF, error 0, resp_valid exactly 2 cycles after accept (LATENCY = 2).
REQ-034 The bench SHALL cover: SB addr 0x11, data 0x00000080; then LB 0x11 -> 0xFFFFFF80; LBU 0x11 -> 0x00000080; LW 0x10 -> 0xDEAD80EF.
REQ-035 The bench SHALL cover: LH 0x12 -> 0xFFFFDEAD; LHU 0x12 -> 0x0000DEAD; LW 0x12 -> error 1, rdata 0; LH 0x13 -> error 1; funct3 011 -> error 1.
REQ-036 The bench SHALL cover: SW addr 0x400 (DEPTH 256), data 0x11111111 -> error 1; next LW 0x0 still returns its prior value.
REQ-037 The bench SHALL cover: resp_ready held 0 for 5 cycles in RESP -> resp_valid, rdata and error stable, req_ready 0; a req_valid pulse in that window is never accepted.
REQ-038 The bench SHALL cover: with word 0x20 = 0, SW 0x20 data 0x12345678 then reset in WAIT -> after reset req_ready 1, resp_valid 0; LW 0x20 -> 0x00000000.

Source files
------------

// File: rtl/data_mem_responder_if.sv
// Request/response bus between a load/store initiator and the data memory responder.
interface data_mem_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_error;

  modport master (
    output req_valid, req_write, req_funct3, req_addr, req_wdata, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_error
  );

  modport slave (
    input  req_valid, req_write, req_funct3, req_addr, req_wdata, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_error
  );
endinterface

// File: rtl/data_mem_responder.sv
// Word-organised RV32I data memory with a fixed-latency, one-outstanding request protocol.
// Handles byte/halfword/word loads and stores with alignment, width-code and range checks.
module data_mem_responder #(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned LATENCY     = 2
) (
  input logic                  clk,
  input logic                  reset,
  data_mem_responder_if.slave  bus
);

  localparam int unsigned IdxW = $clog2(DEPTH_WORDS);
  localparam int unsigned CntW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

  state_e          state_q;
  logic [CntW-1:0] cnt_q;

  logic        write_q;
  logic [2:0]  funct3_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;

  logic        resp_valid_q;
  logic [31:0] resp_rdata_q;
  logic        resp_error_q;

  logic [31:0] mem [DEPTH_WORDS];

  logic [IdxW-1:0] idx;
  logic            illegal;
  logic            misaligned;
  logic            out_of_range;
  logic            access_err;
  logic [31:0]     rd_word;
  logic [7:0]      sel_byte;
  logic [15:0]     sel_half;
  logic [31:0]     load_data;
  logic [31:0]     wr_word;

  // Ready is combinational on reset so it reads low in every reset cycle.
  assign bus.req_ready  = (state_q == StIdle) && !reset;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_rdata = resp_rdata_q;
  assign bus.resp_error = resp_error_q;

  assign idx = addr_q[IdxW+1:2];

  // Decode the latched request: error checks, load extraction and store lane merge.
  always_comb begin
    if (write_q) begin
      illegal = !(funct3_q inside {3'b000, 3'b001, 3'b010});
    end else begin
      illegal = !(funct3_q inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
    end
    misaligned   = ((funct3_q[1:0] == 2'b01) && addr_q[0]) ||
                   ((funct3_q[1:0] == 2'b10) && (addr_q[1:0] != 2'b00));
    out_of_range = |addr_q[31:IdxW+2];
    access_err   = illegal || misaligned || out_of_range;

    rd_word  = mem[idx];
    sel_byte = rd_word[{addr_q[1:0], 3'b000} +: 8];
    sel_half = addr_q[1] ? rd_word[31:16] : rd_word[15:0];

    case (funct3_q)
      3'b000:  load_data = {{24{sel_byte[7]}}, sel_byte};
      3'b001:  load_data = {{16{sel_half[15]}}, sel_half};
      3'b010:  load_data = rd_word;
      3'b100:  load_data = {24'h0, sel_byte};
      3'b101:  load_data = {16'h0, sel_half};
      default: load_data = 32'h0;
    endcase

    wr_word = rd_word;
    case (funct3_q[1:0])
      2'b00:   wr_word[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
      2'b01:   wr_word[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
      default: wr_word = wdata_q;
    endcase
  end

  // Request FSM with registered response; memory commits only on the WAIT-to-RESP edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= 32'h0;
      resp_error_q <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (bus.req_valid) begin
            write_q  <= bus.req_write;
            funct3_q <= bus.req_funct3;
            addr_q   <= bus.req_addr;
            wdata_q  <= bus.req_wdata;
            cnt_q    <= CntW'(LATENCY - 1);
            state_q  <= StWait;
          end
        end
        StWait: begin
          if (cnt_q == '0) begin
            if (write_q && !access_err) begin
              mem[idx] <= wr_word;
            end
            resp_rdata_q <= (write_q || access_err) ? 32'h0 : load_data;
            resp_error_q <= access_err;
            resp_valid_q <= 1'b1;
            state_q      <= StResp;
          end else begin
            cnt_q <= cnt_q - CntW'(1);
          end
        end
        StResp: begin
          if (bus.resp_ready) begin
            resp_valid_q <= 1'b0;
            state_q      <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: expected responses are queued when a request is
// driven and popped when the responder presents resp_valid.
module tb_data_mem_responder;

  logic clk;
  logic reset;
  int   n_assert;
  int   n_fail;

  logic [32:0] sb [$];

  data_mem_responder_if bus_if ();

  data_mem_responder #(
    .DEPTH_WORDS (256),
    .LATENCY     (2)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [32:0] obs, input logic [32:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One full transaction; stall > 0 holds resp_ready low that many cycles in RESP.
  task automatic send(input logic wr, input logic [2:0] f3, input logic [31:0] addr,
                      input logic [31:0] wdata, input logic [31:0] exp_rdata,
                      input logic exp_err, input int stall);
    int          lat;
    logic [32:0] got;
    @(negedge clk);
    check("req_ready_idle", {32'h0, bus_if.req_ready}, 33'h1);
    bus_if.req_valid  = 1'b1;
    bus_if.req_write  = wr;
    bus_if.req_funct3 = f3;
    bus_if.req_addr   = addr;
    bus_if.req_wdata  = wdata;
    sb.push_back({exp_err, exp_rdata});
    @(posedge clk);
    #1;
    bus_if.req_valid = 1'b0;
    lat = 0;
    while (bus_if.resp_valid !== 1'b1 && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check("latency", 33'(lat), 33'd2);
    got = (sb.size() != 0) ? sb.pop_front() : 33'h1_FFFF_FFFF;
    check("rdata", {1'b0, bus_if.resp_rdata}, {1'b0, got[31:0]});
    check("error", {32'h0, bus_if.resp_error}, {32'h0, got[32]});
    for (int i = 0; i < stall; i++) begin
      if (i == 1) begin
        bus_if.req_valid  = 1'b1;
        bus_if.req_write  = 1'b1;
        bus_if.req_funct3 = 3'b010;
        bus_if.req_addr   = 32'h0;
        bus_if.req_wdata  = 32'hBADBAD00;
      end
      @(posedge clk);
      #1;
      bus_if.req_valid = 1'b0;
      check("stall_valid", {32'h0, bus_if.resp_valid}, 33'h1);
      check("stall_rdata", {1'b0, bus_if.resp_rdata}, {1'b0, got[31:0]});
      check("stall_error", {32'h0, bus_if.resp_error}, {32'h0, got[32]});
      check("stall_req_ready", {32'h0, bus_if.req_ready}, 33'h0);
    end
    bus_if.resp_ready = 1'b1;
    @(posedge clk);
    #1;
    bus_if.resp_ready = 1'b0;
    check("resp_drop", {32'h0, bus_if.resp_valid}, 33'h0);
  endtask

  initial begin
    n_assert          = 0;
    n_fail            = 0;
    reset             = 1'b1;
    bus_if.req_valid  = 1'b0;
    bus_if.req_write  = 1'b0;
    bus_if.req_funct3 = 3'b000;
    bus_if.req_addr   = 32'h0;
    bus_if.req_wdata  = 32'h0;
    bus_if.resp_ready = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_req_ready", {32'h0, bus_if.req_ready}, 33'h0);
    check("rst_resp_valid", {32'h0, bus_if.resp_valid}, 33'h0);
    check("rst_rdata", {1'b0, bus_if.resp_rdata}, 33'h0);
    check("rst_error", {32'h0, bus_if.resp_error}, 33'h0);
    reset = 1'b0;
    #1;
    check("post_rst_req_ready", {32'h0, bus_if.req_ready}, 33'h1);

    // Seed known words
    send(1'b1, 3'b010, 32'h0,  32'hCAFEF00D, 32'h0, 1'b0, 0);
    send(1'b1, 3'b010, 32'h20, 32'h0,        32'h0, 1'b0, 0);

    // Word store/load
    send(1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 32'h0,        1'b0, 0);
    send(1'b0, 3'b010, 32'h10, 32'h0,        32'hDEADBEEF, 1'b0, 0);

    // Byte store into lane 1, signed/unsigned byte loads
    send(1'b1, 3'b000, 32'h11, 32'h00000080, 32'h0,        1'b0, 0);
    send(1'b0, 3'b000, 32'h11, 32'h0,        32'hFFFFFF80, 1'b0, 0);
    send(1'b0, 3'b100, 32'h11, 32'h0,        32'h00000080, 1'b0, 0);
    send(1'b0, 3'b010, 32'h10, 32'h0,        32'hDEAD80EF, 1'b0, 0);

    // Halfword loads, misalignment and illegal width code
    send(1'b0, 3'b001, 32'h12, 32'h0, 32'hFFFFDEAD, 1'b0, 0);
    send(1'b0, 3'b101, 32'h12, 32'h0, 32'h0000DEAD, 1'b0, 0);
    send(1'b0, 3'b010, 32'h12, 32'h0, 32'h0,        1'b1, 0);
    send(1'b0, 3'b001, 32'h13, 32'h0, 32'h0,        1'b1, 0);
    send(1'b0, 3'b011, 32'h10, 32'h0, 32'h0,        1'b1, 0);

    // Out-of-range store must not alias onto word 0
    send(1'b1, 3'b010, 32'h400, 32'h11111111, 32'h0,        1'b1, 0);
    send(1'b0, 3'b010, 32'h0,   32'h0,        32'hCAFEF00D, 1'b0, 0);

    // Back-pressure in RESP with a stray request pulse that must be ignored
    send(1'b0, 3'b010, 32'h10, 32'h0, 32'hDEAD80EF, 1'b0, 5);
    send(1'b0, 3'b010, 32'h0,  32'h0, 32'hCAFEF00D, 1'b0, 0);

    // Reset while a store is in WAIT discards it
    @(negedge clk);
    bus_if.req_valid  = 1'b1;
    bus_if.req_write  = 1'b1;
    bus_if.req_funct3 = 3'b010;
    bus_if.req_addr   = 32'h20;
    bus_if.req_wdata  = 32'h12345678;
    @(posedge clk);
    #1;
    bus_if.req_valid = 1'b0;
    reset            = 1'b1;
    @(posedge clk);
    #1;
    check("wait_rst_req_ready", {32'h0, bus_if.req_ready}, 33'h0);
    reset = 1'b0;
    #1;
    check("after_rst_req_ready", {32'h0, bus_if.req_ready}, 33'h1);
    check("after_rst_resp_valid", {32'h0, bus_if.resp_valid}, 33'h0);
    repeat (3) @(posedge clk);
    #1;
    check("no_late_resp", {32'h0, bus_if.resp_valid}, 33'h0);
    send(1'b0, 3'b010, 32'h20, 32'h0, 32'h00000000, 1'b0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
